status_cond_unit: RTL and testbench
===================================

# status_cond_unit

Flag-consuming branch resolver for the MIPS-lite datapath. It captures the N/Z/V status flags produced by the ALU and evaluates conditional branch and branch-and-link requests against them. For taken branches it drives a PC redirect and, for linking forms, a register-file write of the return address to $31. It also keeps a saturating count of taken branches.

## Interface
- No parameters; all widths fixed.
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flag_we  in  1  capture alu_n/alu_z/alu_v into the status registers this cycle
- alu_n, alu_z, alu_v  in  1 each  ALU negative/zero/overflow results for the current operation
- cond_valid  in  1  branch request strobe; accepted only when busy=0
- cond_sel  in  4  condition code (see Operation)
- link  in  1  request is a linking form (write return address)
- pc_plus4  in  32  return address / fall-through PC of the requesting instruction
- target  in  32  branch target address
- status_n, status_z, status_v  out  1 each  registered flags
- busy  out  1  unit is not in IDLE; upstream holds its request and stalls PC
- redirect_valid  out  1  one-cycle pulse: load redirect_pc into PC
- redirect_pc  out  32  branch target, valid with redirect_valid
- link_we  out  1  one-cycle register-file write strobe
- link_addr  out  5  constant 5'd31
- link_data  out  32  return address, valid with link_we
- taken_cnt  out  16  saturating count of taken branches

## Operation
- Condition codes: 0000 EQ (Z); 0001 NE (!Z); 0010 MI (N); 0011 PL (!N); 0100 VS (V); 0101 VC (!V); 0110 LT (N^V); 0111 GE (!(N^V)); 1000 LE ((N^V)|Z); 1001 GT (!((N^V)|Z)); 1010 AL (1); 1011-1111 NV (0, never taken).
- Flag forwarding: if flag_we and cond_valid are asserted in the same cycle, the condition is evaluated on alu_n/z/v; otherwise it is evaluated on status_n/z/v.
- FSM states: IDLE, LINK, REDIR.
- IDLE: on cond_valid with the condition true:
  - if link=1, go to LINK and latch pc_plus4 and target;
  - if link=0, go to REDIR and latch target.
  - If the condition is false, stay in IDLE; no outputs; the request is consumed.
- LINK: assert link_we with link_data=latched pc_plus4; then go to REDIR.
- REDIR: assert redirect_valid with redirect_pc=latched target; then go to IDLE.
- busy = (state != IDLE). cond_valid is ignored while busy=1.
- taken_cnt increments by 1 on every accepted taken request (IDLE-state decision). It saturates at 16'hFFFF and never wraps.
- Flag registers load on flag_we regardless of FSM state. A flag update during LINK/REDIR does not alter the branch already in flight.

## Timing
- Reset (asynchronous, rst_n=0):
  - state=IDLE;
  - status_n/z/v=0;
  - busy=0, redirect_valid=0, link_we=0;
  - redirect_pc=0, link_data=0, taken_cnt=0;
  - link_addr=31 (constant).
- Reset asserted mid-operation aborts the branch: no pending link_we or redirect_valid is issued after release.
- Non-link taken branch: request at edge k; redirect_valid high in cycle k+1; busy high in cycle k+1 only.
- Link taken branch: request at edge k; link_we high in cycle k+1; redirect_valid high in cycle k+2; busy high in cycles k+1 and k+2.
- link_we and redirect_valid are never high in the same cycle.
- Back-to-back: a new request is accepted in the cycle after REDIR returns to IDLE.
- Not-taken requests produce zero-latency acceptance and no busy.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset then idle: rst_n=0 for 2 cycles -> all outputs 0, link_addr=31; release with no requests -> outputs unchanged.
- Flag capture and forwarding:
  - flag_we=1, alu_z=1, with cond_valid, cond_sel=EQ, link=0, target=32'h0000_0040 -> redirect_valid one cycle later, redirect_pc=32'h40, status_z=1.
  - Repeat with flag_we=0 and status_z=0 -> no redirect, busy stays 0.
- Signed conditions: status N=1, V=1, Z=0 -> LT not taken, GE taken, GT taken, LE not taken. Separately with N=1, V=0 -> LT taken.
- Branch-and-link: cond_sel=AL, link=1, pc_plus4=32'h0000_1004, target=32'h0000_2000:
  - cycle+1: link_we=1, link_data=32'h1004;
  - cycle+2: redirect_valid=1, redirect_pc=32'h2000;
  - a cond_valid held during busy is ignored.
- Reset mid-operation: assert rst_n=0 in the LINK cycle -> no redirect_valid afterward; state IDLE, taken_cnt=0.
- Counter saturation: preload via 65535 AL requests -> taken_cnt=16'hFFFF; one more -> stays 16'hFFFF; NV requests never increment it.

Source files
------------

// File: rtl/status_cond_unit_if.sv
// rtl/status_cond_unit_if.sv - request, flag and redirect/link signals of the branch resolver
interface status_cond_unit_if;
    logic        flag_we;
    logic        alu_n;
    logic        alu_z;
    logic        alu_v;
    logic        cond_valid;
    logic [3:0]  cond_sel;
    logic        link;
    logic [31:0] pc_plus4;
    logic [31:0] target;

    logic        status_n;
    logic        status_z;
    logic        status_v;
    logic        busy;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        link_we;
    logic [4:0]  link_addr;
    logic [31:0] link_data;
    logic [15:0] taken_cnt;

    modport master (
        output flag_we, alu_n, alu_z, alu_v, cond_valid, cond_sel, link, pc_plus4, target,
        input  status_n, status_z, status_v, busy, redirect_valid, redirect_pc,
               link_we, link_addr, link_data, taken_cnt
    );

    modport slave (
        input  flag_we, alu_n, alu_z, alu_v, cond_valid, cond_sel, link, pc_plus4, target,
        output status_n, status_z, status_v, busy, redirect_valid, redirect_pc,
               link_we, link_addr, link_data, taken_cnt
    );
endinterface

// File: rtl/status_cond_unit.sv
// rtl/status_cond_unit.sv - N/Z/V status capture and conditional branch / branch-and-link resolver
module status_cond_unit (
    input  logic             clk,
    input  logic             rst_n,
    status_cond_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LINK  = 2'd1,
        REDIR = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        status_n_q, status_n_d;
    logic        status_z_q, status_z_d;
    logic        status_v_q, status_v_d;
    logic        busy_q, busy_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        link_we_q, link_we_d;
    logic [31:0] link_data_q, link_data_d;
    logic [31:0] target_q, target_d;
    logic [15:0] taken_cnt_q, taken_cnt_d;

    logic eval_n, eval_z, eval_v;
    logic cond_true;

    function automatic logic cond_eval(input logic [3:0] sel, input logic n, input logic z,
                                       input logic v);
        logic r;
        case (sel)
            4'h0:    r = z;
            4'h1:    r = !z;
            4'h2:    r = n;
            4'h3:    r = !n;
            4'h4:    r = v;
            4'h5:    r = !v;
            4'h6:    r = n ^ v;
            4'h7:    r = !(n ^ v);
            4'h8:    r = (n ^ v) | z;
            4'h9:    r = !((n ^ v) | z);
            4'hA:    r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Same-cycle flag write is forwarded so a compare-and-branch pair needs no bubble
    always_comb begin
        eval_n = bus.flag_we ? bus.alu_n : status_n_q;
        eval_z = bus.flag_we ? bus.alu_z : status_z_q;
        eval_v = bus.flag_we ? bus.alu_v : status_v_q;
        cond_true = cond_eval(bus.cond_sel, eval_n, eval_z, eval_v);
    end

    always_comb begin
        state_d          = state_q;
        status_n_d       = bus.flag_we ? bus.alu_n : status_n_q;
        status_z_d       = bus.flag_we ? bus.alu_z : status_z_q;
        status_v_d       = bus.flag_we ? bus.alu_v : status_v_q;
        busy_d           = busy_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        link_we_d        = 1'b0;
        link_data_d      = link_data_q;
        target_d         = target_q;
        taken_cnt_d      = taken_cnt_q;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (bus.cond_valid && cond_true) begin
                    busy_d   = 1'b1;
                    target_d = bus.target;
                    if (taken_cnt_q != 16'hFFFF) begin
                        taken_cnt_d = taken_cnt_q + 16'd1;
                    end
                    if (bus.link) begin
                        state_d     = LINK;
                        link_we_d   = 1'b1;
                        link_data_d = bus.pc_plus4;
                    end else begin
                        state_d          = REDIR;
                        redirect_valid_d = 1'b1;
                        redirect_pc_d    = bus.target;
                    end
                end
            end
            LINK: begin
                state_d          = REDIR;
                busy_d           = 1'b1;
                redirect_valid_d = 1'b1;
                redirect_pc_d    = target_q;
            end
            REDIR: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            status_n_q       <= 1'b0;
            status_z_q       <= 1'b0;
            status_v_q       <= 1'b0;
            busy_q           <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'd0;
            link_we_q        <= 1'b0;
            link_data_q      <= 32'd0;
            target_q         <= 32'd0;
            taken_cnt_q      <= 16'd0;
        end else begin
            state_q          <= state_d;
            status_n_q       <= status_n_d;
            status_z_q       <= status_z_d;
            status_v_q       <= status_v_d;
            busy_q           <= busy_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            link_we_q        <= link_we_d;
            link_data_q      <= link_data_d;
            target_q         <= target_d;
            taken_cnt_q      <= taken_cnt_d;
        end
    end

    assign bus.status_n       = status_n_q;
    assign bus.status_z       = status_z_q;
    assign bus.status_v       = status_v_q;
    assign bus.busy           = busy_q;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.link_we        = link_we_q;
    assign bus.link_addr      = 5'd31;
    assign bus.link_data      = link_data_q;
    assign bus.taken_cnt      = taken_cnt_q;

endmodule

// File: tb/tb_status_cond_unit.sv
// tb/tb_status_cond_unit.sv - directed bench for status_cond_unit
module tb_status_cond_unit;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    status_cond_unit_if bus ();

    status_cond_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_flags(input logic n, input logic z, input logic v);
        bus.flag_we = 1'b1;
        bus.alu_n   = n;
        bus.alu_z   = z;
        bus.alu_v   = v;
        tick();
        bus.flag_we = 1'b0;
    endtask

    task automatic req(input logic [3:0] sel, input logic lnk, input logic [31:0] pc,
                       input logic [31:0] tgt);
        bus.cond_valid = 1'b1;
        bus.cond_sel   = sel;
        bus.link       = lnk;
        bus.pc_plus4   = pc;
        bus.target     = tgt;
        tick();
        bus.cond_valid = 1'b0;
        bus.link       = 1'b0;
        bus.flag_we    = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.flag_we    = 1'b0;
        bus.alu_n      = 1'b0;
        bus.alu_z      = 1'b0;
        bus.alu_v      = 1'b0;
        bus.cond_valid = 1'b0;
        bus.cond_sel   = 4'h0;
        bus.link       = 1'b0;
        bus.pc_plus4   = 32'd0;
        bus.target     = 32'd0;

        // reset
        tick();
        tick();
        chk("rst_status", 32'({bus.status_n, bus.status_z, bus.status_v}), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_redir_valid", 32'(bus.redirect_valid), 32'h0);
        chk("rst_link_we", 32'(bus.link_we), 32'h0);
        chk("rst_redir_pc", bus.redirect_pc, 32'h0);
        chk("rst_link_data", bus.link_data, 32'h0);
        chk("rst_taken_cnt", 32'(bus.taken_cnt), 32'h0);
        chk("rst_link_addr", 32'(bus.link_addr), 32'd31);

        rst_n = 1'b1;
        tick();
        chk("idle_busy", 32'(bus.busy), 32'h0);
        chk("idle_redir_valid", 32'(bus.redirect_valid), 32'h0);

        // forwarded flag write with branch in same cycle
        bus.flag_we = 1'b1;
        bus.alu_z   = 1'b1;
        req(4'h0, 1'b0, 32'h0, 32'h0000_0040);
        chk("fwd_redir_valid", 32'(bus.redirect_valid), 32'h1);
        chk("fwd_redir_pc", bus.redirect_pc, 32'h0000_0040);
        chk("fwd_status_z", 32'(bus.status_z), 32'h1);
        chk("fwd_busy", 32'(bus.busy), 32'h1);
        chk("fwd_link_we", 32'(bus.link_we), 32'h0);
        tick();
        chk("fwd_done_valid", 32'(bus.redirect_valid), 32'h0);
        chk("fwd_done_busy", 32'(bus.busy), 32'h0);

        // EQ on registered Z=0 is not taken
        set_flags(1'b0, 1'b0, 1'b0);
        req(4'h0, 1'b0, 32'h0, 32'h0000_0080);
        chk("eq_nt_valid", 32'(bus.redirect_valid), 32'h0);
        chk("eq_nt_busy", 32'(bus.busy), 32'h0);
        chk("eq_nt_status_z", 32'(bus.status_z), 32'h0);
        chk("eq_nt_cnt", 32'(bus.taken_cnt), 32'h1);

        // N=1 V=1 Z=0
        set_flags(1'b1, 1'b0, 1'b1);
        chk("flags_nzv", 32'({bus.status_n, bus.status_z, bus.status_v}), 32'h5);
        req(4'h6, 1'b0, 32'h0, 32'h0000_0100);
        chk("lt_nt_valid", 32'(bus.redirect_valid), 32'h0);
        chk("lt_nt_busy", 32'(bus.busy), 32'h0);
        req(4'h7, 1'b0, 32'h0, 32'h0000_0200);
        chk("ge_t_valid", 32'(bus.redirect_valid), 32'h1);
        chk("ge_t_pc", bus.redirect_pc, 32'h0000_0200);
        tick();
        req(4'h9, 1'b0, 32'h0, 32'h0000_0300);
        chk("gt_t_valid", 32'(bus.redirect_valid), 32'h1);
        chk("gt_t_pc", bus.redirect_pc, 32'h0000_0300);
        tick();
        req(4'h8, 1'b0, 32'h0, 32'h0000_0400);
        chk("le_nt_valid", 32'(bus.redirect_valid), 32'h0);
        chk("le_nt_busy", 32'(bus.busy), 32'h0);
        chk("signed_cnt", 32'(bus.taken_cnt), 32'h3);

        // N=1 V=0
        set_flags(1'b1, 1'b0, 1'b0);
        req(4'h6, 1'b0, 32'h0, 32'h0000_0500);
        chk("lt_t_valid", 32'(bus.redirect_valid), 32'h1);
        chk("lt_t_pc", bus.redirect_pc, 32'h0000_0500);
        tick();
        chk("lt_cnt", 32'(bus.taken_cnt), 32'h4);

        // branch-and-link, with a request held while busy
        req(4'hA, 1'b1, 32'h0000_1004, 32'h0000_2000);
        chk("bal_link_we", 32'(bus.link_we), 32'h1);
        chk("bal_link_data", bus.link_data, 32'h0000_1004);
        chk("bal_redir_early", 32'(bus.redirect_valid), 32'h0);
        chk("bal_busy1", 32'(bus.busy), 32'h1);
        bus.cond_valid = 1'b1;
        bus.cond_sel   = 4'hA;
        bus.link       = 1'b0;
        bus.target     = 32'h0000_3000;
        tick();
        chk("bal_redir_valid", 32'(bus.redirect_valid), 32'h1);
        chk("bal_redir_pc", bus.redirect_pc, 32'h0000_2000);
        chk("bal_link_we_off", 32'(bus.link_we), 32'h0);
        chk("bal_busy2", 32'(bus.busy), 32'h1);
        tick();
        bus.cond_valid = 1'b0;
        chk("bal_done_busy", 32'(bus.busy), 32'h0);
        chk("bal_done_valid", 32'(bus.redirect_valid), 32'h0);
        chk("bal_ignored_pc", bus.redirect_pc, 32'h0000_2000);
        chk("bal_cnt", 32'(bus.taken_cnt), 32'h5);

        // reset during LINK cycle aborts the branch
        req(4'hA, 1'b1, 32'h0000_5004, 32'h0000_6000);
        chk("abort_in_link", 32'(bus.link_we), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("abort_link_we", 32'(bus.link_we), 32'h0);
        chk("abort_busy", 32'(bus.busy), 32'h0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_no_redir", 32'(bus.redirect_valid), 32'h0);
        end
        chk("abort_cnt", 32'(bus.taken_cnt), 32'h0);
        chk("abort_busy_after", 32'(bus.busy), 32'h0);

        // NV codes never taken
        req(4'hB, 1'b0, 32'h0, 32'h0000_7000);
        req(4'hF, 1'b1, 32'h0, 32'h0000_7000);
        chk("nv_cnt", 32'(bus.taken_cnt), 32'h0);
        chk("nv_link_we", 32'(bus.link_we), 32'h0);

        // saturation: preload near the top
        force dut.taken_cnt_q = 16'hFFFE;
        #1;
        release dut.taken_cnt_q;
        req(4'hA, 1'b0, 32'h0, 32'h0000_8000);
        tick();
        chk("sat_reach", 32'(bus.taken_cnt), 32'h0000_FFFF);
        req(4'hA, 1'b0, 32'h0, 32'h0000_9000);
        chk("sat_redir_valid", 32'(bus.redirect_valid), 32'h1);
        tick();
        chk("sat_hold", 32'(bus.taken_cnt), 32'h0000_FFFF);
        req(4'hC, 1'b0, 32'h0, 32'h0000_A000);
        chk("sat_nv", 32'(bus.taken_cnt), 32'h0000_FFFF);
        chk("sat_nv_busy", 32'(bus.busy), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
